// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, grant ids, counter width.
package data_mem_arb_pkg;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_e;

  localparam logic [CntWidth-1:0] CntMax = '1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of CPU, DMA and memory-port signals around the data-memory arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);

  logic                 cpu_req;
  logic                 cpu_we;
  logic [AddrWidth-1:0] cpu_addr;
  logic [DataWidth-1:0] cpu_wdata;
  logic [DataWidth-1:0] cpu_rdata;
  logic                 cpu_ack;
  logic                 cpu_stall;

  logic                 dma_req;
  logic                 dma_we;
  logic [AddrWidth-1:0] dma_addr;
  logic [DataWidth-1:0] dma_wdata;
  logic [DataWidth-1:0] dma_rdata;
  logic                 dma_ack;

  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic                 mem_re;
  logic                 mem_we;
  logic [DataWidth-1:0] mem_rdata;

  logic                 busy;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata,
    output busy
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/data_mem_arbiter_select.sv
// CPU-priority picker with a starvation counter that forces a DMA win after
// StarveLimit consecutive losses.
module mem_arb_select
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned StarveLimit = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic arb_en_i,
  output gnt_e gnt_c_o
);

  logic [CntWidth-1:0] starve_q;
  logic [CntWidth-1:0] starve_d;

  always_comb begin
    gnt_c_o  = GNT_CPU;
    starve_d = starve_q;
    if (dma_req_i && (!cpu_req_i || (starve_q >= CntWidth'(StarveLimit)))) begin
      gnt_c_o = GNT_DMA;
    end
    // Counter only moves on cycles that actually start an access
    if (arb_en_i) begin
      if (!dma_req_i || (gnt_c_o == GNT_DMA)) begin
        starve_d = '0;
      end else if (starve_q != CntMax) begin
        starve_d = starve_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single memory data port between CPU and DMA with fixed wait
// states and a one-cycle ack pulse per access.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WaitStates  = 1,
  parameter int unsigned StarveLimit = 3
) (
  input  logic               clk,
  input  logic               RESET,
  data_mem_arbiter_if.slave  bus
);

  state_e               state_q;
  gnt_e                 gnt_q;
  logic [CntWidth-1:0]  wait_q;
  logic                 we_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [DataWidth-1:0] mem_wdata_q;
  logic                 mem_re_q;
  logic                 mem_we_q;
  logic                 cpu_ack_q;
  logic                 dma_ack_q;
  logic [DataWidth-1:0] cpu_rdata_q;
  logic [DataWidth-1:0] dma_rdata_q;
  logic                 busy_q;

  gnt_e                 gnt_c;
  logic                 arb_en_c;
  logic                 sel_we_c;
  logic [AddrWidth-1:0] sel_addr_c;
  logic [DataWidth-1:0] sel_wdata_c;

  assign arb_en_c = (state_q == IDLE) && (bus.cpu_req || bus.dma_req);

  mem_arb_select #(
    .StarveLimit (StarveLimit)
  ) u_sel (
    .clk       (clk),
    .rst       (RESET),
    .cpu_req_i (bus.cpu_req),
    .dma_req_i (bus.dma_req),
    .arb_en_i  (arb_en_c),
    .gnt_c_o   (gnt_c)
  );

  always_comb begin
    sel_we_c    = bus.cpu_we;
    sel_addr_c  = bus.cpu_addr;
    sel_wdata_c = bus.cpu_wdata;
    if (gnt_c == GNT_DMA) begin
      sel_we_c    = bus.dma_we;
      sel_addr_c  = bus.dma_addr;
      sel_wdata_c = bus.dma_wdata;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_CPU;
      wait_q      <= '0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_en_c) begin
            gnt_q       <= gnt_c;
            we_q        <= sel_we_c;
            mem_addr_q  <= sel_addr_c;
            mem_wdata_q <= sel_wdata_c;
            mem_re_q    <= !sel_we_c;
            // With no wait states the first ACCESS cycle is also the last
            mem_we_q    <= sel_we_c && (WaitStates == 0);
            wait_q      <= CntWidth'(WaitStates);
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_q == '0) begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (gnt_q == GNT_DMA) begin
              dma_ack_q <= 1'b1;
              if (!we_q) dma_rdata_q <= bus.mem_rdata;
            end else begin
              cpu_ack_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= bus.mem_rdata;
            end
            state_q <= RESP;
          end else begin
            wait_q   <= wait_q - CntWidth'(1);
            mem_we_q <= we_q && (wait_q == CntWidth'(1));
          end
        end
        RESP: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with WaitStates=1, StarveLimit=3.
module tb_data_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   we_cnt;

  data_mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  data_mem_arbiter #(
    .AddrWidth   (32),
    .DataWidth   (32),
    .WaitStates  (1),
    .StarveLimit (3)
  ) dut (
    .clk   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed word at 0x100, inverted address elsewhere
  assign bus.mem_rdata = (bus.mem_addr == 32'h100) ? 32'hDEAD_BEEF : ~bus.mem_addr;

  always @(posedge clk) begin
    if (bus.mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic exp_gnt [8];
  int   exp_st  [8];
  int   k;
  int   cyc;
  int   we0;

  initial begin
    total = 0; bad = 0; we_cnt = 0;
    exp_gnt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_st  = '{1, 2, 3, 0, 1, 2, 3, 0};
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    tick(); tick();
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_memre", 32'(bus.mem_re), 0);
    chk("rst_memwe", 32'(bus.mem_we), 0);
    chk("rst_addr",  bus.mem_addr, 0);
    chk("rst_ack",   32'({bus.cpu_ack, bus.dma_ack}), 0);
    rst = 1'b0;
    tick();

    // CPU read of 0x100
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
    #1;
    chk("rd_c0_stall", 32'(bus.cpu_stall), 1);
    chk("rd_c0_re",    32'(bus.mem_re), 0);
    tick();
    chk("rd_c1_re",    32'(bus.mem_re), 1);
    chk("rd_c1_addr",  bus.mem_addr, 32'h100);
    chk("rd_c1_busy",  32'(bus.busy), 1);
    chk("rd_c1_ack",   32'(bus.cpu_ack), 0);
    tick();
    chk("rd_c2_re",    32'(bus.mem_re), 1);
    chk("rd_c2_stall", 32'(bus.cpu_stall), 1);
    chk("rd_c2_ack",   32'(bus.cpu_ack), 0);
    tick();
    chk("rd_c3_ack",   32'(bus.cpu_ack), 1);
    chk("rd_c3_data",  bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_c3_re",    32'(bus.mem_re), 0);
    chk("rd_c3_stall", 32'(bus.cpu_stall), 0);
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_c4_ack",   32'(bus.cpu_ack), 0);
    chk("rd_c4_busy",  32'(bus.busy), 0);

    // CPU write 0x104 <= 0x12345678
    we0 = we_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h104; bus.cpu_wdata = 32'h1234_5678;
    tick();
    chk("wr_c1_we",    32'(bus.mem_we), 0);
    chk("wr_c1_re",    32'(bus.mem_re), 0);
    tick();
    chk("wr_c2_we",    32'(bus.mem_we), 1);
    chk("wr_c2_addr",  bus.mem_addr, 32'h104);
    chk("wr_c2_data",  bus.mem_wdata, 32'h1234_5678);
    tick();
    chk("wr_c3_we",    32'(bus.mem_we), 0);
    chk("wr_c3_ack",   32'(bus.cpu_ack), 1);
    chk("wr_c3_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("wr_pulses",   32'(we_cnt - we0), 1);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick();

    // DMA-only back-to-back reads
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h200;
    tick(); tick(); tick();
    chk("dma0_ack",    32'(bus.dma_ack), 1);
    chk("dma0_data",   bus.dma_rdata, 32'hFFFF_FDFF);
    chk("dma0_cpuack", 32'(bus.cpu_ack), 0);
    bus.dma_addr = 32'h204;
    tick();
    chk("dma_gap_ack", 32'(bus.dma_ack), 0);
    tick();
    chk("dma1_addr",   bus.mem_addr, 32'h204);
    tick();
    chk("dma1_early",  32'(bus.dma_ack), 0);
    tick();
    chk("dma1_ack",    32'(bus.dma_ack), 1);
    chk("dma1_data",   bus.dma_rdata, 32'hFFFF_FDFB);
    chk("dma1_cpurd",  bus.cpu_rdata, 32'hDEAD_BEEF);
    bus.dma_req = 1'b0;
    tick();

    // Both requesting continuously: starvation guard
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h400;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h500;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 100) begin
      tick();
      cyc++;
      if (bus.cpu_ack || bus.dma_ack) begin
        chk("arb_gnt",    32'(bus.dma_ack), 32'(exp_gnt[k]));
        chk("arb_onehot", 32'(bus.cpu_ack & bus.dma_ack), 0);
        chk("arb_starve", 32'(dut.u_sel.starve_q), 32'(exp_st[k]));
        k++;
      end
    end
    chk("arb_count", 32'(k), 8);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    tick();

    // Reset during first ACCESS cycle of a write
    we0 = we_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h300; bus.cpu_wdata = 32'hAAAA_5555;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy",  32'(bus.busy), 0);
    chk("rst_mid_we",    32'(bus.mem_we), 0);
    chk("rst_mid_addr",  bus.mem_addr, 0);
    chk("rst_mid_wdata", bus.mem_wdata, 0);
    chk("rst_mid_ack",   32'(bus.cpu_ack), 0);
    chk("rst_mid_rdata", bus.cpu_rdata, 0);
    tick();
    chk("rst_mid_nowe",  32'(we_cnt - we0), 0);
    rst = 1'b0;
    tick();
    chk("post_c1_we",    32'(bus.mem_we), 0);
    tick();
    chk("post_c2_we",    32'(bus.mem_we), 1);
    chk("post_c2_addr",  bus.mem_addr, 32'h300);
    tick();
    chk("post_c3_ack",   32'(bus.cpu_ack), 1);
    chk("post_c3_rdata", bus.cpu_rdata, 0);
    chk("post_pulses",   32'(we_cnt - we0), 1);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick();

    // cpu_req dropped mid-ACCESS
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h108;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("drop_c2_ack",  32'(bus.cpu_ack), 0);
    tick();
    chk("drop_c3_ack",  32'(bus.cpu_ack), 1);
    chk("drop_c3_data", bus.cpu_rdata, 32'hFFFF_FEF7);
    tick();
    chk("drop_c4_ack",  32'(bus.cpu_ack), 0);
    tick(); tick();
    chk("drop_idle_busy", 32'(bus.busy), 0);
    chk("drop_idle_re",   32'(bus.mem_re), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
